// File: rtl/sim_run_ctrl.sv
// ----------------------------------------------------------------------------
// sim_run_ctrl
//
// Reset sequencer and run monitor. After rst_n deasserts, it holds every
// domain reset for RST_CYCLES cycles. It then releases the domains one by one,
// STAGGER cycles apart, with domain 0 released first. Once the last domain is
// released, it counts run cycles until the core signals halt or the cycle
// limit is reached. Both end states are sticky. A restart pulse re-runs the
// whole sequence without a power-on reset. The last exit code is kept across
// a restart.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   halt       one-cycle pulse from the core: program finished
//   halt_code  exit code, valid together with halt
//   restart    one-cycle pulse: re-run the reset sequence
//   sys_rst    active-high reset per domain, bit 0 releases first
//   running    high while in RUN
//   done       sticky, halt was seen in RUN
//   timeout    sticky, run-cycle limit reached
//   exit_code  halt_code latched on the accepted halt
//   cycle_cnt  cycles spent in RUN (saturating)
//
// All outputs are registers, so no input reaches an output combinationally.
// ----------------------------------------------------------------------------
module sim_run_ctrl #(
    parameter int RST_CYCLES     = 25,
    parameter int N_RST          = 2,
    parameter int STAGGER        = 4,
    parameter int TIMEOUT_CYCLES = 500000,
    parameter int CNT_W          = 32,
    parameter int CODE_W         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              halt,
    input  logic [CODE_W-1:0] halt_code,
    input  logic              restart,
    output logic [N_RST-1:0]  sys_rst,
    output logic              running,
    output logic              done,
    output logic              timeout,
    output logic [CODE_W-1:0] exit_code,
    output logic [CNT_W-1:0]  cycle_cnt
);

    // The phase counter is shared by RESET and RELEASE. It must hold the
    // larger of the two terminal values.
    localparam int REL_LAST = (N_RST - 1) * STAGGER;
    localparam int CNT_MAX  = ((RST_CYCLES - 1) > REL_LAST) ? (RST_CYCLES - 1) : REL_LAST;
    localparam int SW       = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [SW-1:0]    RST_END = SW'(RST_CYCLES - 1);
    localparam logic [SW-1:0]    REL_END = SW'(REL_LAST);
    localparam logic             TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_RESET,
        S_RELEASE,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t          state;
    logic [SW-1:0]   cnt;
    logic [N_RST-1:0] rel_clr;
    logic [CNT_W-1:0] cyc_next;
    logic            to_hit;

    // Domain i is released on the RELEASE edge where cnt == i*STAGGER.
    // With STAGGER=0, every bit matches on the first RELEASE edge.
    always_comb begin
        rel_clr = '0;
        for (int i = 0; i < N_RST; i++) begin
            rel_clr[i] = (cnt == SW'(i * STAGGER));
        end
    end

    // Saturating run counter. The timeout compare looks at the value before
    // the increment, so the counter reads TIMEOUT_CYCLES once TIMEOUT is entered.
    assign cyc_next = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + 1'b1;
    assign to_hit   = TO_EN && (cycle_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RESET;
            cnt       <= '0;
            sys_rst   <= '1;
            running   <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            exit_code <= '0;
            cycle_cnt <= '0;
        end else if (restart) begin
            // Restart takes priority over everything, including a halt on the
            // same cycle. In RESET, it just restarts the hold count.
            // exit_code is kept until the next halt.
            state     <= S_RESET;
            cnt       <= '0;
            sys_rst   <= '1;
            running   <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            case (state)
                S_RESET: begin
                    if (cnt == RST_END) begin
                        state <= S_RELEASE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    sys_rst <= sys_rst & ~rel_clr;
                    if (cnt == REL_END) begin
                        state   <= S_RUN;
                        running <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    cycle_cnt <= cyc_next;
                    if (halt) begin
                        // halt beats a coincident timeout
                        state     <= S_DONE;
                        done      <= 1'b1;
                        exit_code <= halt_code;
                        running   <= 1'b0;
                    end else if (to_hit) begin
                        state   <= S_TIMEOUT;
                        timeout <= 1'b1;
                        running <= 1'b0;
                    end
                end
                S_DONE, S_TIMEOUT: begin
                    // Sticky until restart or rst_n.
                    state <= state;
                end
                default: begin
                    state <= S_RESET;
                end
            endcase
        end
    end

endmodule

// File: doc/sim_run_ctrl.md
Name: sim_run_ctrl

Overview:
Synthesizable reset sequencer and run monitor. It replaces ad-hoc reset/timeout code in simulation top levels and also serves as the reset source on the FPGA top. It produces N staggered active-high reset outputs for the core and its peripherals, counts run cycles, and detects program halt or a cycle-count timeout. It latches an exit code and supports restart without a power-on reset.

Parameters:
RST_CYCLES, 25, cycles all reset outputs stay asserted after rst_n deasserts (must be >=1)
N_RST, 2, number of reset domains
STAGGER, 4, cycles between successive domain releases (0 = release all together)
TIMEOUT_CYCLES, 500000, run-cycle limit (0 = timeout disabled)
CNT_W, 32, width of cycle counter
CODE_W, 8, exit-code width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
halt  in  1  one-cycle pulse from core: program finished
halt_code  in  CODE_W  exit code, valid with halt
restart  in  1  one-cycle pulse: re-run the reset sequence
sys_rst  out  N_RST  active-high reset per domain; bit 0 releases first
running  out  1  high in RUN state
done  out  1  sticky: halt seen
timeout  out  1  sticky: timeout reached
exit_code  out  CODE_W  latched halt_code
cycle_cnt  out  CNT_W  cycles spent in RUN

Behaviour:
- Reset is asynchronous and active-low; the rest of the block is synchronous to the rising edge of clk.
- rst_n low (asynchronous): state=RESET, internal cnt=0, sys_rst=all 1s, running=0, done=0, timeout=0, exit_code=0, cycle_cnt=0.
- States: RESET, RELEASE, RUN, DONE, TIMEOUT. Encoding is free.
- RESET:
  - cnt increments each cycle while rst_n is high.
  - On the cycle cnt==RST_CYCLES-1: go to RELEASE and clear cnt.
  - sys_rst stays all 1s throughout.
- RELEASE:
  - sys_rst[i] clears at the clock edge where cnt==i*STAGGER; domain 0 clears on the first RELEASE edge.
  - Once cleared, a bit stays 0 until the block re-enters RESET.
  - After sys_rst[N_RST-1] clears: go to RUN on the same edge.
  - With N_RST=1 or STAGGER=0, RELEASE lasts exactly 1 cycle and all bits clear together.
- RUN:
  - running=1; cycle_cnt increments each cycle and saturates at all 1s.
  - halt=1: go to DONE, done<=1, exit_code<=halt_code. cycle_cnt takes its final increment on that edge.
  - TIMEOUT_CYCLES!=0 and cycle_cnt==TIMEOUT_CYCLES-1 with no halt: go to TIMEOUT, timeout<=1.
  - halt and the timeout condition on the same cycle: halt wins. done=1, timeout stays 0.
- DONE / TIMEOUT:
  - Sticky; cycle_cnt frozen; sys_rst stays 0; running=0.
  - Further halt pulses are ignored; exit_code is not overwritten.
- restart handling:
  - In any state except RESET: next state RESET, cnt=0, sys_rst=all 1s, done=0, timeout=0, cycle_cnt=0.
  - exit_code is kept until the next halt.
  - restart in RESET: cnt restarts from 0 (extends the reset).
  - restart and halt on the same cycle in RUN: restart wins, done stays 0.
- halt outside RUN is ignored.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Power-on, RST_CYCLES=25, N_RST=2, STAGGER=4, release rst_n at t0 -> sys_rst=2'b11 for 25 cycles; bit0 clears at edge 26 and bit1 at edge 30; running rises the same edge bit1 clears.
- In RUN, pulse halt with halt_code=8'h5A after 100 run cycles -> done=1, exit_code=8'h5A, cycle_cnt=100 and frozen; running=0; a second halt with 8'h00 leaves exit_code=8'h5A.
- TIMEOUT_CYCLES=50, no halt -> timeout=1 with cycle_cnt=50 (run cycles 1..50 counted); done=0. Repeat with halt on run cycle 50 -> done=1, timeout=0.
- Pulse restart in DONE -> sys_rst=all 1s next cycle; done=0, cycle_cnt=0, exit_code held; the full sequence repeats with identical timing.
- Assert rst_n low mid-RELEASE (bit0 already 0) -> same cycle, without waiting for clk: sys_rst=all 1s and all outputs at reset values.
- N_RST=1, STAGGER=0, TIMEOUT_CYCLES=0 -> RELEASE lasts 1 cycle; after 10^6 run cycles timeout stays 0.
